seven_segment_scanner: RTL and testbench
========================================

# seven_segment_scanner

Parametrised multiplexed seven-segment display driver for the board's eight-digit common-anode display; successor to the fixed four-plus-four digit controller. It scans `NUM_DIGITS` hex digits from a latched shadow register and adds:

- per-digit decimal points
- PWM brightness control
- anti-ghosting blank interval
- optional leading-zero blanking

It sits at top level, fed by debug/status values such as MIDI words and USB bytes.

## Interface

Parameters:
- `NUM_DIGITS`, 8, number of digits scanned (1..16).
- `SCAN_DIV`, 100_000, clock cycles per digit slot; must be ≥ 2^`BRIGHT_W` + 1.
- `BRIGHT_W`, 4, width of brightness control.

Ports:
- `clk_in`  input  1  system clock, 100 MHz.
- `n_rst_in`  input  1  reset; one clock; reset is synchronous and active-low.
- `val_in`  input  4*NUM_DIGITS  hex value; nibble i → digit i (digit 0 rightmost).
- `dp_in`  input  NUM_DIGITS  decimal-point enables, bit i → digit i.
- `load_in`  input  1  strobe; latches `val_in`/`dp_in` into the shadow register.
- `bright_in`  input  BRIGHT_W  duty level; 0 = dark, 2^W−1 = (2^W−1)/2^W duty.
- `cat_out`  output  7  segment cathodes, active-low, bit0 = a … bit6 = g.
- `dp_out`  output  1  decimal-point cathode, active-low.
- `an_out`  output  NUM_DIGITS  digit anodes, active-low, at most one low.

## Operation

**Shadow register**
- Updated on any cycle with `load_in`=1.
- Otherwise holds its value.
- The display always reads the shadow register, never `val_in` directly.

**Slot counter**
- `slot_cnt` runs 0..`SCAN_DIV`−1 and wraps to 0.
- On wrap, `digit_idx` increments, and wraps from `NUM_DIGITS`−1 to 0.

**Per slot**
- Blank cycle: when `slot_cnt`=0, all anodes are high (anti-ghosting).
- PWM phase: `pwm = (slot_cnt−1) mod 2^BRIGHT_W`.
- The selected anode `an_out[digit_idx]` is low only when `slot_cnt`≠0 AND `pwm` < `bright_in`.

**Decode**
- Standard hex 0–F: A, b, C, d, E, F glyphs.
- `dp_out` = ~`dp_shadow[digit_idx]`.
- Cathodes are driven regardless of anode state.

**Reset** (`n_rst_in`=0 at a clock edge):
- Cleared: `slot_cnt`, `digit_idx`, shadow value, `dp_shadow`.
- `an_out`=all 1, `cat_out`=7'h7F, `dp_out`=1.
- Reset mid-slot aborts scanning immediately.
- Scanning restarts at digit 0 with a blank cycle.

**Boundary rules**
- `load_in` and the slot wrap in the same cycle: the new digit shows the new value from its first lit cycle.
- `bright_in` is sampled live each cycle; a change mid-slot takes effect on the next cycle.
- `NUM_DIGITS`=1: `digit_idx` is constant 0.

## Timing

- All outputs are registered: one cycle latency from `slot_cnt`/`digit_idx`/shadow to pins.
- Shadow update visible on the next cycle; it reaches pins on the following cycle when that digit is selected.
- Frame period = `NUM_DIGITS`×`SCAN_DIV` cycles (8 ms at defaults).
- Lit cycles per slot ≈ (`SCAN_DIV`−1)×`bright_in`/2^`BRIGHT_W`.

## Configuration

Macro `SS_LEADING_ZERO_BLANK_EN`:
- **Defined:**
  - At each load, compute the highest nonzero nibble index h (h=0 if the value is 0).
  - Digits with index > h keep anodes high for their whole slot, unless their `dp_shadow` bit is set; then the digit shows '0' with its dp.
  - Digit 0 is never blanked.
- **Undefined:** all digits are always displayed, including leading zeros; no blanking logic is synthesised.

## Test plan

Bench parameters: `NUM_DIGITS`=8, `SCAN_DIV`=32, `BRIGHT_W`=4.

1. **Reset:** hold `n_rst_in`=0 3 cycles mid-scan → `an_out`=8'hFF, `cat_out`=7'h7F, `dp_out`=1; after release, first lit digit is 0, cycle 2 post-release.
2. **Scan order and decode:** load 32'h0123_4567, `bright_in`=15 → digits 0..7 lit in order, 32 cycles each, showing `cat_out` for 7,6,…,0; digit 0 shows 7'h78 (7); anodes low 15 of 16 PWM phases; `slot_cnt`=0 cycle always dark.
3. **Brightness:** `bright_in`=0 → `an_out`=8'hFF continuously; `bright_in`=4 → exactly 4 lit cycles per 16-cycle PWM window.
4. **Load coincident with slot wrap:** load 32'hFFFF_FFFF on the wrap cycle into digit 3 → digit 3's first lit cycle shows 'F' (7'h0E); old value never appears on digit 3.
5. **Decimal points:** load with `dp_in`=8'b0000_0100 → `dp_out`=0 only while digit 2 is selected.
6. **Leading-zero blank (with `SS_LEADING_ZERO_BLANK_EN`):**
   - Load 32'h0000_00A5 → digits 2..7 never lit; digits 0/1 show 5/A.
   - Load 0 → only digit 0 lit, showing '0'.
   - Without the macro → all 8 digits lit.

Source files
------------

// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner
//   Multiplexed driver for an NUM_DIGITS-digit common-anode seven-segment
//   display. It scans hex digits from a shadow register and supports
//   per-digit decimal points, PWM brightness and a one-cycle anti-ghosting
//   blank at the start of every digit slot.
//   Optional feature macro: SS_LEADING_ZERO_BLANK_EN (leading-zero blanking).
//   All outputs are registered, so pins lag the scan state by one cycle.
module seven_segment_scanner #(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 100_000,
  parameter int BRIGHT_W   = 4
) (
  input  logic                    clk_in,
  input  logic                    n_rst_in,
  input  logic [4*NUM_DIGITS-1:0] val_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load_in,
  input  logic [BRIGHT_W-1:0]     bright_in,
  output logic [6:0]              cat_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an_out
);

  localparam int SLOT_W = $clog2(SCAN_DIV);
  localparam int DIG_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [DIG_W-1:0]  DIG_LAST  = DIG_W'(NUM_DIGITS - 1);

  logic [SLOT_W-1:0]       slot_cnt;
  logic [DIG_W-1:0]        digit_idx;
  logic [4*NUM_DIGITS-1:0] val_shadow;
  logic [NUM_DIGITS-1:0]   dp_shadow;

  logic [3:0]              nib_sel;
  logic                    dp_sel;
  logic [BRIGHT_W-1:0]     pwm_phase;
  logic                    digit_blank;
  logic                    digit_lit;
  logic [6:0]              cat_next;
  logic [NUM_DIGITS-1:0]   an_next;

  // Slot timer and digit pointer: every SCAN_DIV cycles move to the next digit.
  always_ff @(posedge clk_in) begin
    if (!n_rst_in) begin
      slot_cnt  <= '0;
      digit_idx <= '0;
    end else if (slot_cnt == SLOT_LAST) begin
      slot_cnt  <= '0;
      digit_idx <= (digit_idx == DIG_LAST) ? '0 : digit_idx + 1'b1;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  // Shadow register. load_in is a single-cycle strobe with no ready/backpressure:
  // whenever it is high at a clock edge val_in/dp_in are captured, and the
  // display only ever reads the captured copy.
  always_ff @(posedge clk_in) begin
    if (!n_rst_in) begin
      val_shadow <= '0;
      dp_shadow  <= '0;
    end else if (load_in) begin
      val_shadow <= val_in;
      dp_shadow  <= dp_in;
    end
  end

  // Pick the nibble and decimal-point bit of the digit currently scanned.
  always_comb begin
    nib_sel = 4'h0;
    dp_sel  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_idx == DIG_W'(i)) begin
        nib_sel = val_shadow[4*i +: 4];
        dp_sel  = dp_shadow[i];
      end
    end
  end

`ifdef SS_LEADING_ZERO_BLANK_EN
  logic [DIG_W-1:0] lz_top;
  logic [DIG_W-1:0] lz_top_next;

  // Index of the most significant nonzero nibble of the incoming value (0 if all zero).
  always_comb begin
    lz_top_next = '0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (val_in[4*i +: 4] != 4'h0) lz_top_next = DIG_W'(i);
    end
  end

  // Captured alongside the shadow so blanking always matches the displayed value.
  always_ff @(posedge clk_in) begin
    if (!n_rst_in) begin
      lz_top <= '0;
    end else if (load_in) begin
      lz_top <= lz_top_next;
    end
  end

  // Digits above the top nonzero one stay dark unless their decimal point is on.
  assign digit_blank = (digit_idx > lz_top) && !dp_sel;
`else
  assign digit_blank = 1'b0;
`endif

  // PWM phase restarts right after the blank cycle of each slot.
  assign pwm_phase = BRIGHT_W'(slot_cnt - 1'b1);
  assign digit_lit = (slot_cnt != '0) && (pwm_phase < bright_in) && !digit_blank;

  // Drive the selected anode low only while the digit is lit.
  always_comb begin
    an_next = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_idx == DIG_W'(i)) an_next[i] = ~digit_lit;
    end
  end

  // Hex glyph decode, active-low cathodes, bit0 = a ... bit6 = g.
  always_comb begin
    case (nib_sel)
      4'h0:    cat_next = 7'h40;
      4'h1:    cat_next = 7'h79;
      4'h2:    cat_next = 7'h24;
      4'h3:    cat_next = 7'h30;
      4'h4:    cat_next = 7'h19;
      4'h5:    cat_next = 7'h12;
      4'h6:    cat_next = 7'h02;
      4'h7:    cat_next = 7'h78;
      4'h8:    cat_next = 7'h00;
      4'h9:    cat_next = 7'h10;
      4'hA:    cat_next = 7'h08;
      4'hB:    cat_next = 7'h03;
      4'hC:    cat_next = 7'h46;
      4'hD:    cat_next = 7'h21;
      4'hE:    cat_next = 7'h06;
      default: cat_next = 7'h0E;
    endcase
  end

  // Output registers; reset forces every segment and anode off.
  always_ff @(posedge clk_in) begin
    if (!n_rst_in) begin
      an_out  <= '1;
      cat_out <= 7'h7F;
      dp_out  <= 1'b1;
    end else begin
      an_out  <= an_next;
      cat_out <= cat_next;
      dp_out  <= ~dp_sel;
    end
  end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb_seven_segment_scanner
//   Self-checking bench for seven_segment_scanner (NUM_DIGITS=8, SCAN_DIV=32,
//   BRIGHT_W=4). The reference model tracks elapsed cycles since reset and
//   derives digit/slot/PWM phase arithmetically.
module tb_seven_segment_scanner;

  localparam int ND = 8;
  localparam int SD = 32;
  localparam int BW = 4;

  logic          clk_in = 1'b0;
  logic          n_rst_in;
  logic [31:0]   val_in;
  logic [7:0]    dp_in;
  logic          load_in;
  logic [3:0]    bright_in;
  logic [6:0]    cat_out;
  logic          dp_out;
  logic [7:0]    an_out;

  int n_pass  = 0;
  int n_total = 0;

  // model state: m_t = scan position (cycles since reset release) before the next edge
  int          m_t;
  logic [31:0] m_val;
  logic [7:0]  m_dp;
  logic [7:0]  exp_an;
  logic [6:0]  exp_cat;
  logic        exp_dp;

  logic [9:0]  exp_q[$];
  int          lit_cnt[ND];

  // clock / DUT
  always #5 clk_in = ~clk_in;

  seven_segment_scanner #(
    .NUM_DIGITS(ND),
    .SCAN_DIV  (SD),
    .BRIGHT_W  (BW)
  ) dut (
    .clk_in   (clk_in),
    .n_rst_in (n_rst_in),
    .val_in   (val_in),
    .dp_in    (dp_in),
    .load_in  (load_in),
    .bright_in(bright_in),
    .cat_out  (cat_out),
    .dp_out   (dp_out),
    .an_out   (an_out)
  );

  // glyphs written as lit segments (gfedcba), then inverted for common anode
  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] on;
    case (n)
      4'h0: on = 7'h3F; 4'h1: on = 7'h06; 4'h2: on = 7'h5B; 4'h3: on = 7'h4F;
      4'h4: on = 7'h66; 4'h5: on = 7'h6D; 4'h6: on = 7'h7D; 4'h7: on = 7'h07;
      4'h8: on = 7'h7F; 4'h9: on = 7'h6F; 4'hA: on = 7'h77; 4'hB: on = 7'h7C;
      4'hC: on = 7'h39; 4'hD: on = 7'h5E; 4'hE: on = 7'h79; default: on = 7'h71;
    endcase
    return ~on;
  endfunction

  // driver + reference model: applies inputs for one edge and predicts the
  // outputs that edge produces
  task automatic step(input logic rst_n, input logic ld, input logic [31:0] v,
                      input logic [7:0] d, input logic [3:0] b);
    int   dig;
    int   slot;
    int   h;
    logic blank;
    n_rst_in  = rst_n;
    load_in   = ld;
    val_in    = v;
    dp_in     = d;
    bright_in = b;
    @(posedge clk_in);
    if (!rst_n) begin
      exp_an  = 8'hFF;
      exp_cat = 7'h7F;
      exp_dp  = 1'b1;
      m_t     = 0;
      m_val   = '0;
      m_dp    = '0;
    end else begin
      dig   = (m_t / SD) % ND;
      slot  = m_t % SD;
      blank = 1'b0;
      h     = 0;
`ifdef SS_LEADING_ZERO_BLANK_EN
      for (int i = 0; i < ND; i++) if (m_val[4*i +: 4] != 4'h0) h = i;
      blank = (dig > h) && !m_dp[dig];
`endif
      exp_cat = glyph(m_val[4*dig +: 4]);
      exp_dp  = ~m_dp[dig];
      exp_an  = 8'hFF;
      if (slot != 0 && ((slot - 1) % (1 << BW)) < int'(b) && !blank) exp_an[dig] = 1'b0;
      m_t++;
      if (ld) begin
        m_val = v;
        m_dp  = d;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    repeat (2) step(1'b0, 1'b0, 32'h0, 8'h0, 4'd0);
  endtask

  function automatic int lit_index();
    int idx;
    idx = -1;
    for (int i = 0; i < ND; i++) if (an_out[i] == 1'b0) idx = i;
    return idx;
  endfunction

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 50; k++) step(1'b1, k == 0, 32'h89AB_CDEF, 8'h0F, 4'd15);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 32'h0, 8'h0, 4'd15);
      n_total++;
      if (an_out !== 8'hFF || cat_out !== 7'h7F || dp_out !== 1'b1)
        $display("FAIL reset_hold cyc=%0d got an=%h cat=%h dp=%b need an=ff cat=7f dp=1", k, an_out, cat_out, dp_out);
      else n_pass++;
    end
    step(1'b1, 1'b0, 32'h0, 8'h0, 4'd15);
    n_total++;
    if (an_out !== 8'hFF) $display("FAIL reset_release_blank got an=%h need ff", an_out);
    else n_pass++;
    step(1'b1, 1'b0, 32'h0, 8'h0, 4'd15);
    n_total++;
    if (an_out !== 8'hFE || cat_out !== 7'h40 || dp_out !== 1'b1)
      $display("FAIL reset_first_lit got an=%h cat=%h dp=%b need an=fe cat=40 dp=1", an_out, cat_out, dp_out);
    else n_pass++;
  endtask

  task automatic test_scan_order();
    int idx;
    int last;
    logic [9:0] got;
    int exp_lit;
    do_reset();
    exp_q = {};
    for (int d = 0; d < ND; d++) begin
      lit_cnt[d] = 0;
`ifdef SS_LEADING_ZERO_BLANK_EN
      if (d < 7) exp_q.push_back({3'(d), glyph(4'(7 - d))});
`else
      exp_q.push_back({3'(d), glyph(4'(7 - d))});
`endif
    end
    last = -1;
    for (int k = 0; k < ND * SD; k++) begin
      step(1'b1, k == 0, 32'h0123_4567, 8'h00, 4'd15);
      n_total++;
      if ({an_out, cat_out, dp_out} !== {exp_an, exp_cat, exp_dp})
        $display("FAIL scan_model t=%0d got an=%h cat=%h dp=%b need an=%h cat=%h dp=%b", m_t, an_out, cat_out, dp_out, exp_an, exp_cat, exp_dp);
      else n_pass++;
      idx = lit_index();
      if (idx >= 0) begin
        lit_cnt[idx]++;
        if (idx != last) begin
          last = idx;
          got  = {3'(idx), cat_out};
          n_total++;
          if (exp_q.size() == 0) $display("FAIL scan_order unexpected digit %0d lit", idx);
          else if (got !== exp_q[0]) begin
            $display("FAIL scan_order got dig/cat=%h need %h", got, exp_q[0]);
            void'(exp_q.pop_front());
          end else begin
            void'(exp_q.pop_front());
            n_pass++;
          end
        end
      end
    end
    n_total++;
    if (exp_q.size() != 0) $display("FAIL scan_order_left got %0d pending need 0", exp_q.size());
    else n_pass++;
    for (int d = 0; d < ND; d++) begin
      exp_lit = 30;
`ifdef SS_LEADING_ZERO_BLANK_EN
      if (d == 7) exp_lit = 0;
`endif
      n_total++;
      if (lit_cnt[d] != exp_lit) $display("FAIL scan_lit_count dig=%0d got %0d need %0d", d, lit_cnt[d], exp_lit);
      else n_pass++;
    end
  endtask

  task automatic test_brightness();
    int lit_all;
    int lit_win;
    do_reset();
    for (int k = 0; k < 100; k++) begin
      step(1'b1, k == 0, $urandom, 8'($urandom), 4'd0);
      n_total++;
      if (an_out !== 8'hFF) $display("FAIL bright_zero cyc=%0d got an=%h need ff", k, an_out);
      else n_pass++;
    end
    do_reset();
    lit_all = 0;
    lit_win = 0;
    for (int k = 0; k < SD; k++) begin
      step(1'b1, k == 0, 32'h1111_1111, 8'h00, 4'd4);
      if (an_out != 8'hFF) begin
        lit_all++;
        if (k >= 1 && k <= 16) lit_win++;
      end
    end
    n_total++;
    if (lit_win != 4) $display("FAIL bright4_window got %0d lit need 4", lit_win);
    else n_pass++;
    n_total++;
    if (lit_all != 8) $display("FAIL bright4_slot got %0d lit need 8", lit_all);
    else n_pass++;
    // brightness changing every cycle
    for (int k = 0; k < 400; k++) begin
      step(1'b1, $urandom_range(0, 29) == 0, $urandom, 8'($urandom), 4'($urandom_range(0, 15)));
      n_total++;
      if ({an_out, cat_out, dp_out} !== {exp_an, exp_cat, exp_dp})
        $display("FAIL bright_live t=%0d got an=%h cat=%h dp=%b need an=%h cat=%h dp=%b", m_t, an_out, cat_out, dp_out, exp_an, exp_cat, exp_dp);
      else n_pass++;
    end
  endtask

  task automatic test_load_wrap();
    logic seen_first;
    do_reset();
    seen_first = 1'b0;
    for (int k = 0; k < 200; k++) begin
      step(1'b1, (k == 0) || (k == 3 * SD - 1), (k < 3 * SD - 1) ? 32'h0123_4567 : 32'hFFFF_FFFF, 8'h00, 4'd15);
      n_total++;
      if ({an_out, cat_out, dp_out} !== {exp_an, exp_cat, exp_dp})
        $display("FAIL wrap_model t=%0d got an=%h cat=%h dp=%b need an=%h cat=%h dp=%b", m_t, an_out, cat_out, dp_out, exp_an, exp_cat, exp_dp);
      else n_pass++;
      if (an_out[3] == 1'b0) begin
        if (!seen_first) begin
          seen_first = 1'b1;
          n_total++;
          if (cat_out !== 7'h0E) $display("FAIL wrap_first_lit got cat=%h need 0e", cat_out);
          else n_pass++;
        end
        n_total++;
        if (cat_out === 7'h19) $display("FAIL wrap_old_value got cat=%h need not 19", cat_out);
        else n_pass++;
      end
    end
    n_total++;
    if (!seen_first) $display("FAIL wrap_digit3_lit got never lit need lit");
    else n_pass++;
  endtask

  task automatic test_dp();
    int  dig;
    do_reset();
    for (int k = 0; k < ND * SD + 8; k++) begin
      step(1'b1, k == 0, $urandom, 8'b0000_0100, 4'd15);
      if (k >= 1) begin
        dig = ((m_t - 1) / SD) % ND;
        n_total++;
        if (dp_out !== (dig != 2)) $display("FAIL dp_select t=%0d dig=%0d got dp=%b need %b", m_t, dig, dp_out, dig != 2);
        else n_pass++;
      end
    end
  endtask

  task automatic test_leading_zero();
    logic [31:0] v;
    int idx;
    int exp_lit;
    for (int r = 0; r < 2; r++) begin
      v = (r == 0) ? 32'h0000_00A5 : 32'h0;
      do_reset();
      for (int d = 0; d < ND; d++) lit_cnt[d] = 0;
      for (int k = 0; k < ND * SD; k++) begin
        step(1'b1, k == 0, v, 8'h00, 4'd15);
        n_total++;
        if ({an_out, cat_out, dp_out} !== {exp_an, exp_cat, exp_dp})
          $display("FAIL lz_model t=%0d got an=%h cat=%h dp=%b need an=%h cat=%h dp=%b", m_t, an_out, cat_out, dp_out, exp_an, exp_cat, exp_dp);
        else n_pass++;
        idx = lit_index();
        if (idx >= 0) lit_cnt[idx]++;
        if (idx == 0) begin
          n_total++;
          if (cat_out !== ((r == 0) ? 7'h12 : 7'h40)) $display("FAIL lz_digit0 r=%0d got cat=%h", r, cat_out);
          else n_pass++;
        end
        if (idx == 1 && r == 0) begin
          n_total++;
          if (cat_out !== 7'h08) $display("FAIL lz_digit1 got cat=%h need 08", cat_out);
          else n_pass++;
        end
      end
      for (int d = 0; d < ND; d++) begin
        exp_lit = 30;
`ifdef SS_LEADING_ZERO_BLANK_EN
        if (d > ((r == 0) ? 1 : 0)) exp_lit = 0;
`endif
        n_total++;
        if (lit_cnt[d] != exp_lit) $display("FAIL lz_lit_count r=%0d dig=%0d got %0d need %0d", r, d, lit_cnt[d], exp_lit);
        else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    logic rst_n;
    logic ld;
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      ld    = ($urandom_range(0, 19) == 0) || ((m_t % SD) == SD - 1 && $urandom_range(0, 1) == 1);
      step(rst_n, ld, $urandom, 8'($urandom), 4'($urandom_range(0, 15)));
      n_total++;
      if ({an_out, cat_out, dp_out} !== {exp_an, exp_cat, exp_dp})
        $display("FAIL random_model t=%0d got an=%h cat=%h dp=%b need an=%h cat=%h dp=%b", m_t, an_out, cat_out, dp_out, exp_an, exp_cat, exp_dp);
      else n_pass++;
      n_total++;
      if ($countones(~an_out) > 1) $display("FAIL one_hot_anode got an=%h need at most one low", an_out);
      else n_pass++;
    end
  endtask

  initial begin
    n_rst_in  = 1'b0;
    load_in   = 1'b0;
    val_in    = '0;
    dp_in     = '0;
    bright_in = '0;
    test_reset();
    test_scan_order();
    test_brightness();
    test_load_wrap();
    test_dp();
    test_leading_zero();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
